// File: rtl/dsp_pkg.sv
// Shared constants and types for the DSP P-output round/saturate block.
// Widths, FIFO depth, round-mode names and the buffered sample bundle.
package dsp_pkg;

  localparam int P_W        = 48;
  localparam int OUT_W      = 18;
  localparam int FIFO_DEPTH = 4;
  localparam int PTR_W      = 2;
  localparam int CNT_W      = 3;

  localparam string RND_NEAREST = "NEAREST";
  localparam string RND_TRUNC   = "TRUNC";

  typedef struct packed {
    logic             sat;
    logic [OUT_W-1:0] data;
  } sample_t;

endpackage

// File: rtl/dsp_out_fifo.sv
// 4-deep output FIFO of {sat, data} samples; ports: clk/rst_n, push/din,
// pop/dout (zero when empty), count, full, empty. Full+pop+push is legal.
module dsp_out_fifo
  import dsp_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  sample_t          din,
  input  logic             pop,
  output sample_t          dout,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  sample_t          mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_pop;
  logic             do_push;

  assign full    = (count == CNT_W'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  // a pop frees the slot the same edge, so full does not block push then
  assign do_push = push & (~full | do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/dsp_p_round_sat.sv
// Rounds, shifts and saturates the 48-bit DSP P output to 18 bits, then
// buffers it. Ports: CLK/RSTN, P_IN/P_VALID in; DOUT/DOUT_SAT/DOUT_VALID,
// DOUT_READY handshake; COUNT occupancy; OVF_STICKY drop flag, CLR_OVF.
module dsp_p_round_sat
  import dsp_pkg::*;
#(
  parameter int    SHIFT      = 17,
  parameter string ROUND_MODE = "NEAREST",
  parameter bit    SAT_EN     = 1'b1
) (
  input  logic             CLK,
  input  logic             RSTN,
  input  logic [P_W-1:0]   P_IN,
  input  logic             P_VALID,
  output logic [OUT_W-1:0] DOUT,
  output logic             DOUT_SAT,
  output logic             DOUT_VALID,
  input  logic             DOUT_READY,
  output logic [CNT_W-1:0] COUNT,
  output logic             OVF_STICKY,
  input  logic             CLR_OVF
);

  localparam logic [P_W:0] ONE = (P_W+1)'(1);
  localparam logic [P_W:0] RND_K =
    (ROUND_MODE == RND_NEAREST) ? (ONE << (SHIFT-1)) : '0;
  localparam logic signed [P_W:0] MAX_V =
    (P_W+1)'((1 << (OUT_W-1)) - 1);
  localparam logic signed [P_W:0] MIN_V = ~MAX_V;

  logic signed [P_W:0] s1_sum;
  logic                s1_valid;
  logic signed [P_W:0] shifted;
  sample_t             s2_next;
  sample_t             s2_q;
  logic                s2_valid;
  sample_t             head;
  logic                fifo_full;
  logic                fifo_empty;
  logic                drop;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      s1_valid <= P_VALID;
      s2_valid <= s1_valid;
    end
  end

  always_ff @(posedge CLK) begin
    s1_sum <= $signed({P_IN[P_W-1], P_IN}) + $signed(RND_K);
    s2_q   <= s2_next;
  end

  assign shifted = s1_sum >>> SHIFT;

  always_comb begin
    s2_next.data = shifted[OUT_W-1:0];
    s2_next.sat  = 1'b0;
    if (SAT_EN) begin
      if (shifted > MAX_V) begin
        s2_next.data = MAX_V[OUT_W-1:0];
        s2_next.sat  = 1'b1;
      end else if (shifted < MIN_V) begin
        s2_next.data = MIN_V[OUT_W-1:0];
        s2_next.sat  = 1'b1;
      end
    end
  end

  dsp_out_fifo u_fifo (
    .clk   (CLK),
    .rst_n (RSTN),
    .push  (s2_valid),
    .din   (s2_q),
    .pop   (DOUT_READY),
    .dout  (head),
    .count (COUNT),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // full implies non-empty, so a ready consumer always makes room
  assign drop = s2_valid & fifo_full & ~DOUT_READY;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN)        OVF_STICKY <= 1'b0;
    else if (drop)    OVF_STICKY <= 1'b1;
    else if (CLR_OVF) OVF_STICKY <= 1'b0;
  end

  assign DOUT       = head.data;
  assign DOUT_SAT   = head.sat;
  assign DOUT_VALID = ~fifo_empty;

endmodule
